bcd_bounce_counter: RTL and testbench
=====================================

# bcd_bounce_counter

Parametrised multi-digit BCD counter with run-time lower/upper limits and three counting modes: ping-pong, wrap-up and wrap-down. It is the next-generation ping-pong counter for display and sequencing datapaths. It adds per-cycle enable, synchronous load, a direction output, turnaround/wrap pulses and configuration-error detection. It drives seven-segment decoders and timing sequencers directly from its registered count.

## Interface
- `DIGITS`, default 2: number of BCD digits, legal range 1..8. W = 4*DIGITS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: when high, the counter advances one step on this edge.
- `mode` in 2: 00 ping-pong, 01 wrap-up, 10 wrap-down, 11 freeze (count holds, turn/wrap stay low).
- `lo` in W: BCD lower limit, sampled every cycle.
- `hi` in W: BCD upper limit, sampled every cycle.
- `load` in 1: synchronous load strobe.
- `load_val` in W: BCD value loaded when `load` is high.
- `count` out W: registered BCD count. Digit 0 is bits [3:0].
- `dir` out 1: direction of the next ping-pong step, 1 = up, 0 = down.
- `turn` out 1: registered one-cycle pulse on a ping-pong direction reversal.
- `wrap` out 1: registered one-cycle pulse on a wrap-mode rollover.
- `cfg_err` out 1: registered flag. High when `lo > hi`, or when any nibble of `lo`/`hi` is greater than 9.

## Operation
- Reset values: `count` = 0, `dir` = 1, `turn` = 0, `wrap` = 0, `cfg_err` = 0.
- Per-edge priority: `rst` > `load` > `cfg_err` condition > `en`.
- Load:
  - `count` <= `load_val` and `dir` <= 1. `turn` and `wrap` are 0.
  - `load_val` is not range-checked. A non-BCD nibble is loaded as-is and is corrected by the out-of-range rule.
- Config error: when `lo`/`hi` are invalid this cycle, `cfg_err` <= 1 next edge. `count` and `dir` hold, and `en` is ignored. `cfg_err` clears on the first edge where the config is valid.
- Out-of-range rule: applies on an enabled step in any active mode. If `count < lo`, `count > hi`, or `count` has a non-BCD nibble, then `count` <= `lo` and `dir` <= 1. No pulse.
- BCD arithmetic: ±1 per step with per-digit carry/borrow. Digit 9+1 gives 0 with carry; digit 0−1 gives 9 with borrow. Comparisons are unsigned on the full W-bit BCD word, which is valid for BCD.
- Ping-pong, endpoints visited once with no dwell:
  - UP state (`dir` = 1): `count` <= `count`+1. If the new value equals `hi`, then `dir` <= 0 and `turn` <= 1.
  - DOWN state (`dir` = 0): `count` <= `count`−1. If the new value equals `lo`, then `dir` <= 1 and `turn` <= 1.
  - If `count` == `hi` and `dir` = 1 (reached after a load), step down immediately: `dir` <= 0, `turn` <= 1.
  - If `count` == `lo` and `dir` = 0, step up immediately: `dir` <= 1, `turn` <= 1.
  - If `lo` == `hi`: `count` holds, `dir` toggles and `turn` = 1 on every enabled edge.
- Wrap-up: at `hi`, next value is `lo` with `wrap` <= 1. Otherwise +1. `dir` is forced to 1.
- Wrap-down: at `lo`, next value is `hi` with `wrap` <= 1. Otherwise −1. `dir` is forced to 0.
- Mode change mid-count: takes effect on the next enabled edge from the current `count`, then the rules above apply.
- Limits change mid-count: handled by the out-of-range rule. No other side effects.

## Timing
- Every output is a flop. There is no combinational path from inputs to outputs.
- Latency: `count`, `dir`, `turn` and `wrap` reflect an enabled step one edge after `en` is sampled high.
- `turn`/`wrap` assert in the same cycle as the `count` value that caused them, and last exactly one cycle unless re-triggered.
- `en` low: all state holds, and `turn`/`wrap` drop to 0 on the next edge.
- `rst` asserted mid-cycle clears all outputs immediately, regardless of `clk`. On release, the first enabled edge steps from 0.
- Critical path: DIGITS-deep BCD carry chain plus a W-bit compare. It must close at the target clock for DIGITS = 8.

## Test plan
- Reset/async: DIGITS = 2, count running at 37, pulse `rst` between edges. Expect `count` = 00 and `dir` = 1 immediately, and `turn`/`wrap`/`cfg_err` = 0.
- Ping-pong with BCD carry: `lo` = 07, `hi` = 12, `en` = 1. Expect sequence 08,09,10,11,12(turn),11,10,09,08,07(turn),08. Check the 09→10 carry and the 10→09 borrow.
- Wrap modes: mode 01 with `lo` = 95, `hi` = 99 gives 96..99 then 95 with `wrap` = 1. Mode 10 from 95 gives 99 with `wrap` = 1.
- Load/priority: `load` = 1, `en` = 1, `load_val` = 99, range 00–50. Expect `count` = 99, `dir` = 1. The next enabled edge gives 00 (lo) with no pulse.
- Config error: `lo` = 30, `hi` = 20, then `hi` = 2A. Expect `cfg_err` = 1 and `count` frozen. Restoring `hi` = 40 clears `cfg_err` on the next edge and counting resumes.
- Degenerate and enable: `lo` = `hi` = 05 holds 05 while `dir` toggles and `turn` = 1 every edge. Toggle `en` mid-sweep and confirm hold with no pulses.

Source files
------------

// File: rtl/bcd_bounce_counter.sv
// Multi-digit BCD counter with run-time limits: ping-pong, wrap-up and wrap-down modes,
// synchronous load, turnaround/wrap pulses and configuration-error detection.
module bcd_bounce_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   lo,
    input  logic [4*DIGITS-1:0]   hi,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  dir,
    output logic                  turn,
    output logic                  wrap,
    output logic                  cfg_err
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        MODE_PP  = 2'b00,
        MODE_UP  = 2'b01,
        MODE_DN  = 2'b10,
        MODE_FRZ = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // BCD increment with per-digit carry
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement with per-digit borrow
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic non_bcd(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    logic [W-1:0] count_q, count_d;
    dir_e         dir_q, dir_d;
    logic         turn_q, turn_d;
    logic         wrap_q, wrap_d;
    logic         cfg_err_q, cfg_err_d;

    logic [W-1:0] inc_c;
    logic [W-1:0] dec_c;
    logic         cfg_bad_c;
    logic         oor_c;
    logic         go_up_c;
    mode_e        mode_c;

    assign inc_c     = bcd_inc(count_q);
    assign dec_c     = bcd_dec(count_q);
    assign cfg_bad_c = (lo > hi) || non_bcd(lo) || non_bcd(hi);
    assign oor_c     = (count_q < lo) || (count_q > hi) || non_bcd(count_q);
    assign mode_c    = mode_e'(mode);
    // Endpoints are not dwelt on: a count sitting at a limit heads away from it.
    assign go_up_c   = ((dir_q == DIR_UP) && (count_q != hi)) ||
                       ((dir_q == DIR_DN) && (count_q == lo));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            dir_q     <= DIR_UP;
            turn_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            turn_q    <= turn_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        turn_d    = 1'b0;
        wrap_d    = 1'b0;
        cfg_err_d = cfg_bad_c;

        if (load) begin
            count_d = load_val;
            dir_d   = DIR_UP;
        end else if (cfg_bad_c) begin
            count_d = count_q;
        end else if (en && (mode_c != MODE_FRZ)) begin
            if (oor_c) begin
                count_d = lo;
                dir_d   = DIR_UP;
            end else begin
                unique case (mode_c)
                    MODE_PP: begin
                        if (lo == hi) begin
                            dir_d  = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
                            turn_d = 1'b1;
                        end else if (go_up_c) begin
                            count_d = inc_c;
                            if (inc_c == hi) begin
                                dir_d  = DIR_DN;
                                turn_d = 1'b1;
                            end else begin
                                dir_d  = DIR_UP;
                                turn_d = (dir_q == DIR_DN);
                            end
                        end else begin
                            count_d = dec_c;
                            if (dec_c == lo) begin
                                dir_d  = DIR_UP;
                                turn_d = 1'b1;
                            end else begin
                                dir_d  = DIR_DN;
                                turn_d = (dir_q == DIR_UP);
                            end
                        end
                    end
                    MODE_UP: begin
                        dir_d = DIR_UP;
                        if (count_q == hi) begin
                            count_d = lo;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = inc_c;
                        end
                    end
                    MODE_DN: begin
                        dir_d = DIR_DN;
                        if (count_q == lo) begin
                            count_d = hi;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = dec_c;
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign turn    = turn_q;
    assign wrap    = wrap_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_bcd_bounce_counter.sv
// Scoreboard bench for bcd_bounce_counter (DIGITS = 2): directed vectors push expected
// outputs into a queue that a monitor drains one entry per clock edge.
module tb_bcd_bounce_counter;

    typedef struct packed {
        logic [7:0] count;
        logic       dir;
        logic       turn;
        logic       wrap;
        logic       cfg;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       dir;
    logic       turn;
    logic       wrap;
    logic       cfg_err;

    logic [1:0] s_mode;
    logic [7:0] s_lo;
    logic [7:0] s_hi;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    bcd_bounce_counter #(.DIGITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .dir      (dir),
        .turn     (turn),
        .wrap     (wrap),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input exp_t e);
        exp_t got;
        got = '{count: count, dir: dir, turn: turn, wrap: wrap, cfg: cfg_err};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got count=%h dir=%b turn=%b wrap=%b cfg_err=%b, expected count=%h dir=%b turn=%b wrap=%b cfg_err=%b",
                     name, got.count, got.dir, got.turn, got.wrap, got.cfg,
                     e.count, e.dir, e.turn, e.wrap, e.cfg);
        end
    endtask

    // Monitor: one scoreboard entry per edge, sampled after the edge settles
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] l, input logic [7:0] h);
        s_mode = m;
        s_lo   = l;
        s_hi   = h;
    endtask

    task automatic step(input string name, input logic e, input logic ld, input logic [7:0] lv,
                        input logic [7:0] ec, input logic ed, input logic et,
                        input logic ew, input logic ecf);
        @(negedge clk);
        en       = e;
        load     = ld;
        load_val = lv;
        mode     = s_mode;
        lo       = s_lo;
        hi       = s_hi;
        exp_q.push_back('{count: ec, dir: ed, turn: et, wrap: ew, cfg: ecf});
        name_q.push_back(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        mode     = 2'b00;
        lo       = 8'h00;
        hi       = 8'h00;
        set_cfg(2'b00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        compare("reset_state", '{count: 8'h00, dir: 1'b1, turn: 1'b0, wrap: 1'b0, cfg: 1'b0});
        rst = 1'b0;

        // Ping-pong 07..12 with carry/borrow and an enable gap after the turn
        set_cfg(2'b00, 8'h07, 8'h12);
        step("pp_load",   1, 1, 8'h07, 8'h07, 1, 0, 0, 0);
        step("pp_08",     1, 0, 8'h00, 8'h08, 1, 0, 0, 0);
        step("pp_09",     1, 0, 8'h00, 8'h09, 1, 0, 0, 0);
        step("pp_carry",  1, 0, 8'h00, 8'h10, 1, 0, 0, 0);
        step("pp_11",     1, 0, 8'h00, 8'h11, 1, 0, 0, 0);
        step("pp_turn_hi",1, 0, 8'h00, 8'h12, 0, 1, 0, 0);
        step("pp_en_off", 0, 0, 8'h00, 8'h12, 0, 0, 0, 0);
        step("pp_11d",    1, 0, 8'h00, 8'h11, 0, 0, 0, 0);
        step("pp_10d",    1, 0, 8'h00, 8'h10, 0, 0, 0, 0);
        step("pp_borrow", 1, 0, 8'h00, 8'h09, 0, 0, 0, 0);
        step("pp_08d",    1, 0, 8'h00, 8'h08, 0, 0, 0, 0);
        step("pp_turn_lo",1, 0, 8'h00, 8'h07, 1, 1, 0, 0);
        step("pp_08u",    1, 0, 8'h00, 8'h08, 1, 0, 0, 0);

        // Async reset between edges while running at 37
        set_cfg(2'b00, 8'h00, 8'h99);
        step("rst_load",  1, 1, 8'h36, 8'h36, 1, 0, 0, 0);
        step("rst_37",    1, 0, 8'h00, 8'h37, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        en   = 1'b0;
        load = 1'b0;
        rst  = 1'b1;
        #1;
        compare("rst_async", '{count: 8'h00, dir: 1'b1, turn: 1'b0, wrap: 1'b0, cfg: 1'b0});
        #1;
        rst = 1'b0;
        step("rst_first", 1, 0, 8'h00, 8'h01, 1, 0, 0, 0);

        // Wrap-up 95..99, then wrap-down
        set_cfg(2'b01, 8'h95, 8'h99);
        step("wu_oor",    1, 0, 8'h00, 8'h95, 1, 0, 0, 0);
        step("wu_96",     1, 0, 8'h00, 8'h96, 1, 0, 0, 0);
        step("wu_97",     1, 0, 8'h00, 8'h97, 1, 0, 0, 0);
        step("wu_98",     1, 0, 8'h00, 8'h98, 1, 0, 0, 0);
        step("wu_99",     1, 0, 8'h00, 8'h99, 1, 0, 0, 0);
        step("wu_wrap",   1, 0, 8'h00, 8'h95, 1, 0, 1, 0);
        step("wu_96b",    1, 0, 8'h00, 8'h96, 1, 0, 0, 0);
        set_cfg(2'b10, 8'h95, 8'h99);
        step("wd_95",     1, 0, 8'h00, 8'h95, 0, 0, 0, 0);
        step("wd_wrap",   1, 0, 8'h00, 8'h99, 0, 0, 1, 0);
        step("wd_98",     1, 0, 8'h00, 8'h98, 0, 0, 0, 0);

        // Load priority over enable, non-BCD load corrected to lo
        set_cfg(2'b00, 8'h00, 8'h50);
        step("ld_99",     1, 1, 8'h99, 8'h99, 1, 0, 0, 0);
        step("ld_oor",    1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        step("ld_nonbcd", 1, 1, 8'h3C, 8'h3C, 1, 0, 0, 0);
        step("ld_fix",    1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        step("ld_01",     1, 0, 8'h00, 8'h01, 1, 0, 0, 0);

        // Configuration errors freeze the count; load still wins
        set_cfg(2'b00, 8'h30, 8'h20);
        step("cfg_lo_gt", 1, 0, 8'h00, 8'h01, 1, 0, 0, 1);
        set_cfg(2'b00, 8'h30, 8'h2A);
        step("cfg_2a",    1, 0, 8'h00, 8'h01, 1, 0, 0, 1);
        set_cfg(2'b00, 8'h10, 8'h2A);
        step("cfg_nib",   1, 0, 8'h00, 8'h01, 1, 0, 0, 1);
        step("cfg_load",  1, 1, 8'h35, 8'h35, 1, 0, 0, 1);
        set_cfg(2'b00, 8'h30, 8'h40);
        step("cfg_clear", 1, 0, 8'h00, 8'h36, 1, 0, 0, 0);
        step("cfg_37",    1, 0, 8'h00, 8'h37, 1, 0, 0, 0);

        // Degenerate lo == hi, enable gap, freeze mode
        set_cfg(2'b00, 8'h05, 8'h05);
        step("dg_oor",    1, 0, 8'h00, 8'h05, 1, 0, 0, 0);
        step("dg_t1",     1, 0, 8'h00, 8'h05, 0, 1, 0, 0);
        step("dg_t2",     1, 0, 8'h00, 8'h05, 1, 1, 0, 0);
        step("dg_t3",     1, 0, 8'h00, 8'h05, 0, 1, 0, 0);
        step("dg_en_off", 0, 0, 8'h00, 8'h05, 0, 0, 0, 0);
        step("dg_t4",     1, 0, 8'h00, 8'h05, 1, 1, 0, 0);
        set_cfg(2'b11, 8'h05, 8'h05);
        step("frz_hold",  1, 0, 8'h00, 8'h05, 1, 0, 0, 0);
        set_cfg(2'b11, 8'h00, 8'h02);
        step("frz_oor",   1, 0, 8'h00, 8'h05, 1, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
